sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro (14-bit word address, 32-bit data, active-low byte write enables, CS/OE) between two requesters: instruction-side and data-side slave wrappers.
- Grants one requester at a time for a whole burst of 1..16 beats.
- Generates the macro control pins cycle by cycle and returns read data, which has one cycle of latency.
- Sits between the slave wrappers and the SRAM macro instance.

Parameters:
- NREQ, 2, number of requesters (the design and tests cover 2 only).
- AW, 14, SRAM word-address width.
- DW, 32, data width.

Ports:
- CK  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  burst request, held until done.
- req_addr  in  NREQ*AW  start word address.
- req_len  in  NREQ*4  beats minus 1.
- req_write  in  NREQ  1 = write burst.
- wvalid  in  NREQ  write beat valid.
- wstrb  in  NREQ*4  active-high byte enables.
- wdata  in  NREQ*DW  write data.
- gnt  out  NREQ  one-hot grant, held for the whole burst.
- wready  out  NREQ  write beat accepted.
- rvalid  out  NREQ  read beat valid; carries no backpressure.
- rdata  out  DW  read data, shared by all requesters.
- rlast  out  1  final read beat.
- done  out  NREQ  1-cycle pulse when the burst completes.
- sram_A  out  AW  macro address.
- sram_DI  out  DW  macro write data.
- sram_WEB  out  4  macro byte write enables, active-low.
- sram_OE  out  1  macro output enable.
- sram_CS  out  1  macro chip select.
- sram_DO  in  DW  macro read data.

Behaviour:
- Reset values: gnt/wready/rvalid/rlast/done=0; rdata=0; sram_A=0; sram_DI=0; sram_WEB=4'hF; sram_OE=0; sram_CS=0; rr_ptr=0 (requester 0 preferred).
- States:
  - IDLE: no burst in progress.
  - ARB: registered pick of the winner.
  - RD: read beats issuing.
  - WR: write beats issuing.
  - RTAIL: waiting for the last read data.
  - DONE: completion pulse.
- IDLE: any req goes to ARB.
- ARB: winner = lowest index at or after rr_ptr with req=1. gnt asserts in the next cycle. Latch addr, len and write; beat_cnt=0. Go to RD or WR.
- RD:
  - Each cycle: sram_CS=1, sram_OE=1, sram_WEB=F, sram_A=addr+beat_cnt, then beat_cnt++.
  - After the beat where beat_cnt==len, go to RTAIL.
  - rvalid for the granted requester asserts exactly one cycle after each issue, with rdata=sram_DO. rlast accompanies the beat len.
- RTAIL: drives the last rvalid/rlast, then goes to DONE.
- WR:
  - wready[g]=1. When wvalid[g]=1: sram_CS=1, sram_WEB=~wstrb[g], sram_DI=wdata[g], sram_A=addr+beat_cnt, beat_cnt++.
  - When wvalid=0: sram_WEB=F and there is no advance.
  - After the beat where beat_cnt==len, go to DONE.
- DONE: done[g]=1 for 1 cycle; gnt drops; rr_ptr=g+1 mod NREQ; return to IDLE.
- Address arithmetic is mod 2^AW; wrap 3FFF→0000 is legal and silent.
- Simultaneous requests: round-robin decides. A requester deasserting req mid-burst is ignored; the burst completes.
- len=0 gives a single beat. Throughput for a read burst of N beats: N+3 cycles from ARB to DONE.
- Reset mid-burst: immediately return to IDLE with all outputs at reset values. No partial write is committed after rst rises.

Optional Feature:
- Macro SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins ARB when requesting, and rr_ptr is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package sram_arb_pkg:
  - state enum typedef (IDLE, ARB, RD, WR, RTAIL, DONE).
  - SRAM_WEB_IDLE = 4'hF.
  - LEN_W = 4.
- One sub-module, sram_rr_picker: combinational round-robin or fixed winner from req and rr_ptr, outputs a one-hot vector plus valid.
- FSM, counters and pin muxing stay in sram_port_arbiter.

Test Plan:
- Read, requester 1 alone: addr=0x0010, len=3, memory preloaded with 0xA0..A3 → sram_A = 0x10..0x13 on consecutive cycles; rvalid[1] on 4 consecutive cycles with rdata A0..A3; rlast on 0xA3; done[1] pulse; sram_WEB stays F.
- Write with stalls: requester 0, addr=0x3FFE, len=2, wstrb=4'b0101, wvalid low 2 cycles before the second beat → writes to 3FFE, 3FFF, 0000; sram_WEB=4'b1010 only on accepted beats; readback matches the enabled bytes only.
- Contention: req=2'b11 from reset → gnt order 01, 10, 01 across three back-to-back bursts. With SRAM_ARB_FIXED_PRIO_EN: 01, 01, 01 while req[0] is held.
- Reset mid-write: assert rst after beat 1 of 4 → outputs at reset values in the same cycle; beats 2–3 are not written; the next request is arbitrated normally.
- Request withdrawn: req[0] drops after ARB with len=1 → both beats still issued; done[0] pulses once.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;
  localparam int LEN_W = 4;
  localparam logic [3:0] SRAM_WEB_IDLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    RTAIL = 3'd4,
    DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Combinational winner pick: lowest index at or after i_rr_ptr with a request.
// Fixed priority falls out when the pointer is tied to zero.
module sram_rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_win_oh,
  output logic [PW-1:0]   o_win_idx,
  output logic            o_vld
);
  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    o_vld     = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester is written last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[(int'(i_rr_ptr) + i) % NREQ]) begin
        o_vld     = 1'b1;
        o_win_idx = PW'((int'(i_rr_ptr) + i) % NREQ);
      end
    end
    o_win_oh[o_win_idx] = o_vld;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between burst requesters; read data returns one cycle after issue.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 14,
  parameter int DW   = 32
) (
  input  logic                  CK,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ-1:0]       wvalid,
  input  logic [NREQ*4-1:0]     wstrb,
  input  logic [NREQ*DW-1:0]    wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       wready,
  output logic [NREQ-1:0]       rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  rlast,
  output logic [NREQ-1:0]       done,
  output logic [AW-1:0]         sram_A,
  output logic [DW-1:0]         sram_DI,
  output logic [3:0]            sram_WEB,
  output logic                  sram_OE,
  output logic                  sram_CS,
  input  logic [DW-1:0]         sram_DO
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            r_state, w_state_nxt;
  logic [PW-1:0]     r_gidx, w_rr_ptr, w_win_idx;
  logic [NREQ-1:0]   r_gnt_oh, w_win_oh;
  logic              w_win_vld;
  logic [AW-1:0]     r_addr;
  logic [LEN_W-1:0]  r_len, r_beat_cnt;
  logic              r_rvalid, r_rlast;
  logic              w_beat, w_last;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [PW-1:0] r_rr_ptr;

  always_ff @(posedge CK or posedge rst) begin
    if (rst)
      r_rr_ptr <= '0;
    else if (r_state == DONE)
      r_rr_ptr <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  sram_rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .i_req     (req),
    .i_rr_ptr  (w_rr_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_vld     (w_win_vld)
  );

  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gidx     <= '0;
      r_gnt_oh   <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // Macro read data appears one cycle after the issue cycle.
      r_rvalid <= (r_state == RD);
      r_rlast  <= (r_state == RD) && w_last;
      if (r_state == ARB) begin
        r_gidx     <= w_win_idx;
        r_gnt_oh   <= w_win_oh;
        r_addr     <= req_addr[w_win_idx*AW +: AW];
        r_len      <= req_len[w_win_idx*LEN_W +: LEN_W];
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_last      = (r_beat_cnt == r_len);
    gnt         = '0;
    wready      = '0;
    done        = '0;
    sram_A      = '0;
    sram_DI     = '0;
    sram_WEB    = SRAM_WEB_IDLE;
    sram_OE     = 1'b0;
    sram_CS     = 1'b0;
    unique case (r_state)
      IDLE: if (|req) w_state_nxt = ARB;
      ARB: begin
        if (!w_win_vld)                w_state_nxt = IDLE;
        else if (req_write[w_win_idx]) w_state_nxt = WR;
        else                           w_state_nxt = RD;
      end
      RD: begin
        gnt     = r_gnt_oh;
        w_beat  = 1'b1;
        sram_CS = 1'b1;
        sram_OE = 1'b1;
        sram_A  = r_addr + AW'(r_beat_cnt);
        if (w_last) w_state_nxt = RTAIL;
      end
      WR: begin
        gnt     = r_gnt_oh;
        wready  = r_gnt_oh;
        sram_A  = r_addr + AW'(r_beat_cnt);
        sram_DI = wdata[r_gidx*DW +: DW];
        if (wvalid[r_gidx]) begin
          w_beat   = 1'b1;
          sram_CS  = 1'b1;
          sram_WEB = ~wstrb[r_gidx*4 +: 4];
          if (w_last) w_state_nxt = DONE;
        end
      end
      RTAIL: begin
        gnt         = r_gnt_oh;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = r_gnt_oh;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rvalid = r_rvalid ? r_gnt_oh : '0;
  assign rdata  = r_rvalid ? sram_DO : '0;
  assign rlast  = r_rlast;
endmodule
